// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//
// Bit-serial adder sequencer. A single full-adder slice, built from two `ha`
// half-adder cells and an OR gate, is time-shared across WIDTH bit positions,
// LSB first. A carry flip-flop links successive steps. The sequencer sits
// behind a Start/Done handshake, and it exposes its result only after the add
// has completed.
//
// Ports (serial_add_ctrl):
//   Clk    in   1      rising-edge clock
//   Reset  in   1      asynchronous, active-high; clears all state
//   Start  in   1      request pulse, sampled only while idle
//   A      in   WIDTH  addend, captured on the accept edge
//   B      in   WIDTH  addend, captured on the accept edge
//   Cin    in   1      carry-in, captured on the accept edge
//   Busy   out  1      high while bits are being processed
//   Done   out  1      one-cycle completion strobe
//   Sum    out  WIDTH  registered result, updated only on completion
//   Cout   out  1      registered carry-out, updated only on completion
//
// Ports (ha):
//   c  out  carry (a & b)
//   s  out  sum   (a ^ b)
//   a  in   operand bit
//   b  in   operand bit
// -----------------------------------------------------------------------------

module ha (
  output logic c,
  output logic s,
  input  logic a,
  input  logic b
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  // One extra bit so the counter can reach WIDTH without wrapping.
  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nx_s;

  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-1:0] res_sr_r;
  logic             carry_r;
  logic [CW-1:0]    count_r;

  logic [WIDTH-1:0] a_sr_nx_s;
  logic [WIDTH-1:0] b_sr_nx_s;
  logic [WIDTH-1:0] res_sr_nx_s;
  logic             carry_nx_s;
  logic [CW-1:0]    count_nx_s;
  logic             busy_nx_s;
  logic             done_nx_s;
  logic [WIDTH-1:0] sum_nx_s;
  logic             cout_nx_s;

  logic             a_bit_s;
  logic             b_bit_s;
  logic             c1_s;
  logic             s1_s;
  logic             c2_s;
  logic             s_bit_s;
  logic             slice_cout_s;
  logic [WIDTH-1:0] res_shift_s;
  logic             res_lsb_unused_s;

  // Full-adder slice: two half adders plus an OR on the carries.
  assign a_bit_s = a_sr_r[0];
  assign b_bit_s = b_sr_r[0];

  ha u0 (
    .c (c1_s),
    .s (s1_s),
    .a (a_bit_s),
    .b (b_bit_s)
  );

  ha u1 (
    .c (c2_s),
    .s (s_bit_s),
    .a (s1_s),
    .b (carry_r)
  );

  assign slice_cout_s = c1_s | c2_s;

  // New sum bit enters from the MSB side; on the final step this word is the
  // complete result. The oldest bit (res_sr_r[0]) falls off and is never read.
  assign res_shift_s      = {s_bit_s, res_sr_r[WIDTH-1:1]};
  assign res_lsb_unused_s = res_sr_r[0];

  // Next-state and next-value logic for the sequencer and its datapath.
  always_comb begin
    state_nx_s  = state_r;
    a_sr_nx_s   = a_sr_r;
    b_sr_nx_s   = b_sr_r;
    res_sr_nx_s = res_sr_r;
    carry_nx_s  = carry_r;
    count_nx_s  = count_r;
    busy_nx_s   = Busy;
    done_nx_s   = Done;
    sum_nx_s    = Sum;
    cout_nx_s   = Cout;

    case (state_r)
      IDLE: begin
        if (Start) begin
          a_sr_nx_s  = A;
          b_sr_nx_s  = B;
          carry_nx_s = Cin;
          count_nx_s = {CW{1'b0}};
          busy_nx_s  = 1'b1;
          state_nx_s = RUN;
        end else begin
          state_nx_s = IDLE;
        end
      end

      RUN: begin
        a_sr_nx_s   = {1'b0, a_sr_r[WIDTH-1:1]};
        b_sr_nx_s   = {1'b0, b_sr_r[WIDTH-1:1]};
        res_sr_nx_s = res_shift_s;
        carry_nx_s  = slice_cout_s;
        count_nx_s  = count_r + CW'(1);
        if (count_r == LAST) begin
          // Final bit: publish the whole word at once so Sum never shows a
          // partial result.
          sum_nx_s   = res_shift_s;
          cout_nx_s  = slice_cout_s;
          done_nx_s  = 1'b1;
          busy_nx_s  = 1'b0;
          state_nx_s = DONE;
        end else begin
          state_nx_s = RUN;
        end
      end

      DONE: begin
        // Start is deliberately not looked at here.
        done_nx_s  = 1'b0;
        state_nx_s = IDLE;
      end

      default: begin
        busy_nx_s  = 1'b0;
        done_nx_s  = 1'b0;
        state_nx_s = IDLE;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      a_sr_r   <= {WIDTH{1'b0}};
      b_sr_r   <= {WIDTH{1'b0}};
      res_sr_r <= {WIDTH{1'b0}};
      carry_r  <= 1'b0;
      count_r  <= {CW{1'b0}};
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Sum      <= {WIDTH{1'b0}};
      Cout     <= 1'b0;
    end else begin
      a_sr_r   <= a_sr_nx_s;
      b_sr_r   <= b_sr_nx_s;
      res_sr_r <= res_sr_nx_s;
      carry_r  <= carry_nx_s;
      count_r  <= count_nx_s;
      Busy     <= busy_nx_s;
      Done     <= done_nx_s;
      Sum      <= sum_nx_s;
      Cout     <= cout_nx_s;
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
//
// Directed and random checks of serial_add_ctrl. A WIDTH=8 instance takes the
// directed steps, and a WIDTH=4 instance joins the random back-to-back run.
// Expected results come from plain integer addition of the captured operands,
// and expected timing comes from the documented cycle counts.
// -----------------------------------------------------------------------------

module tb_serial_add_ctrl;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = 8'h00;
  logic [7:0] b8 = 8'h00;
  logic       cin8 = 1'b0;
  logic       busy8;
  logic       done8;
  logic [7:0] sum8;
  logic       cout8;

  logic       start4 = 1'b0;
  logic [3:0] a4 = 4'h0;
  logic [3:0] b4 = 4'h0;
  logic       cin4 = 1'b0;
  logic       busy4;
  logic       done4;
  logic [3:0] sum4;
  logic       cout4;

  int errors = 0;
  int checks = 0;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (start8),
    .A     (a8),
    .B     (b8),
    .Cin   (cin8),
    .Busy  (busy8),
    .Done  (done8),
    .Sum   (sum8),
    .Cout  (cout8)
  );

  serial_add_ctrl #(.WIDTH(4)) dut4 (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (start4),
    .A     (a4),
    .B     (b4),
    .Cin   (cin4),
    .Busy  (busy4),
    .Done  (done4),
    .Sum   (sum4),
    .Cout  (cout4)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // One WIDTH=8 operation. With poke set, Start is pulsed again before edges
  // k+3 and k+8 using A=B=1; those requests must be ignored.
  task automatic do_op8(input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input bit poke);
    logic [8:0] exp;
    logic [7:0] old_sum;
    logic       old_cout;
    exp      = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    old_sum  = sum8;
    old_cout = cout8;
    a8       = a;
    b8       = b;
    cin8     = cin;
    start8   = 1'b1;
    tick();                                  // accept edge k
    for (int j = 1; j <= 8; j++) begin
      start8 = poke && (j == 3 || j == 8);
      a8     = poke ? 8'h01 : 8'($urandom);
      b8     = poke ? 8'h01 : 8'($urandom);
      cin8   = 1'($urandom);
      chk("run_busy", busy8, 1'b1);
      chk("run_done", done8, 1'b0);
      chk("run_sum_hold", sum8, old_sum);
      chk("run_cout_hold", cout8, old_cout);
      tick();                                // edge k+j
    end
    start8 = 1'b0;
    chk("fin_done", done8, 1'b1);
    chk("fin_busy", busy8, 1'b0);
    chk("fin_sum", sum8, exp[7:0]);
    chk("fin_cout", cout8, exp[8]);
    tick();                                  // edge k+9: back to idle
    chk("post_done", done8, 1'b0);
    chk("post_busy", busy8, 1'b0);
    chk("post_sum", sum8, exp[7:0]);
    tick();                                  // nothing may have been started
    chk("idle_done", done8, 1'b0);
    chk("idle_busy", busy8, 1'b0);
    chk("idle_sum", sum8, exp[7:0]);
    chk("idle_cout", cout8, exp[8]);
  endtask

  logic [7:0] ah8 [0:2999];
  logic [7:0] bh8 [0:2999];
  logic       ch8 [0:2999];
  logic [3:0] ah4 [0:2999];
  logic [3:0] bh4 [0:2999];
  logic       ch4 [0:2999];

  initial begin
    logic [8:0] e8;
    logic [4:0] e4;
    logic [8:0] held8;
    logic [4:0] held4;
    int prev8;
    int prev4;
    int n8;
    int n4;
    int idx;

    // Reset without any clock edge.
    #2 Reset = 1'b1;
    #1;
    chk("rst_busy", busy8, 1'b0);
    chk("rst_done", done8, 1'b0);
    chk("rst_sum", sum8, 8'h00);
    chk("rst_cout", cout8, 1'b0);
    chk("rst_sum4", sum4, 4'h0);
    @(negedge Clk);
    Reset = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("quiet_busy", busy8, 1'b0);
      chk("quiet_done", done8, 1'b0);
      chk("quiet_sum", sum8, 8'h00);
      chk("quiet_cout", cout8, 1'b0);
      tick();
    end

    // Basic add and full carry propagation.
    do_op8(8'h5A, 8'h3C, 1'b0, 1'b0);
    do_op8(8'hFF, 8'h01, 1'b0, 1'b0);
    do_op8(8'hFF, 8'hFF, 1'b1, 1'b0);

    // Start while busy / on the completion edge is ignored.
    do_op8(8'h12, 8'h34, 1'b0, 1'b1);

    // Reset mid-run discards the in-flight result.
    a8     = 8'h77;
    b8     = 8'h11;
    cin8   = 1'b0;
    start8 = 1'b1;
    tick();                                  // accept edge k
    start8 = 1'b0;
    tick();                                  // k+1
    tick();                                  // k+2
    #3 Reset = 1'b1;                         // between edges, before k+3
    #1;
    chk("mid_rst_busy", busy8, 1'b0);
    chk("mid_rst_done", done8, 1'b0);
    chk("mid_rst_sum", sum8, 8'h00);
    chk("mid_rst_cout", cout8, 1'b0);
    tick();
    chk("mid_rst_hold_busy", busy8, 1'b0);
    @(negedge Clk);
    Reset = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("after_rst_done", done8, 1'b0);
      chk("after_rst_busy", busy8, 1'b0);
      tick();
    end
    do_op8(8'h10, 8'h20, 1'b1, 1'b0);

    // Random back-to-back run with Start held high on both widths.
    prev8  = -1;
    prev4  = -1;
    n8     = 0;
    n4     = 0;
    held8  = 9'd0;
    held4  = 5'd0;
    start8 = 1'b1;
    start4 = 1'b1;
    for (int c = 0; c < 2400 && (n8 < 200 || n4 < 200); c++) begin
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      cin8 = 1'($urandom);
      a4 = 4'($urandom);
      b4 = 4'($urandom);
      cin4 = 1'($urandom);
      ah8[c] = a8;
      bh8[c] = b8;
      ch8[c] = cin8;
      ah4[c] = a4;
      bh4[c] = b4;
      ch4[c] = cin4;
      tick();                                // edge c
      if (done8) begin
        idx = (c >= 8) ? c - 8 : 0;          // operands were captured WIDTH edges ago
        e8 = {1'b0, ah8[idx]} + {1'b0, bh8[idx]} + {8'd0, ch8[idx]};
        chk("rnd8_sum", sum8, e8[7:0]);
        chk("rnd8_cout", cout8, e8[8]);
        if (prev8 >= 0) chk("rnd8_spacing", c - prev8, 10);
        prev8 = c;
        held8 = e8;
        n8++;
      end else if (n8 > 0) begin
        chk("rnd8_hold", {cout8, sum8}, held8);
      end
      if (done4) begin
        idx = (c >= 4) ? c - 4 : 0;
        e4 = {1'b0, ah4[idx]} + {1'b0, bh4[idx]} + {4'd0, ch4[idx]};
        chk("rnd4_sum", sum4, e4[3:0]);
        chk("rnd4_cout", cout4, e4[4]);
        if (prev4 >= 0) chk("rnd4_spacing", c - prev4, 6);
        prev4 = c;
        held4 = e4;
        n4++;
      end else if (n4 > 0) begin
        chk("rnd4_hold", {cout4, sum4}, held4);
      end
    end
    start8 = 1'b0;
    start4 = 1'b0;
    chk("rnd8_op_count", n8 >= 200, 1'b1);
    chk("rnd4_op_count", n4 >= 200, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial add sequencer built around the team's `ha` half-adder cell. Two `ha` instances plus an OR form a single full-adder slice. The controller time-shares that slice across WIDTH bit positions, LSB first, with a carry flip-flop between steps. It is a small-area alternative to a ripple adder and sits behind a simple Start/Done handshake.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  asynchronous, active-high; clears all state
Start  input  1  request pulse; sampled only in IDLE
A  input  WIDTH  addend, captured on the Start-accept edge
B  input  WIDTH  addend, captured on the Start-accept edge
Cin  input  1  carry-in, captured on the Start-accept edge
Busy  output  1  high while the add is in progress (RUN state)
Done  output  1  one-cycle completion strobe
Sum  output  WIDTH  registered result
Cout  output  1  registered carry-out

Behaviour:
- Clocking and reset: one clock, Clk. Reset is asynchronous and active-high.
- Reset values: state=IDLE, Busy=0, Done=0, Sum=0, Cout=0, shift registers=0, carry FF=0, bit counter=0.
- Datapath slice:
  - ha u0(c1,s1,a_bit,b_bit); ha u1(c2,s_bit,s1,carry_q).
  - Carry out of the slice is c1|c2.
  - a_bit and b_bit are the LSBs of the A and B shift registers.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On an edge with Start=1: load A, B into shift regs, carry_q<=Cin, count<=0, go to RUN, Busy<=1.
  - Otherwise hold.
- RUN (one bit per edge):
  - A/B shift regs shift right by 1.
  - s_bit enters the result shift reg from the MSB side, shifting it right.
  - carry_q<=c1|c2, count<=count+1.
  - On the edge where count==WIDTH-1:
    - Sum<={s_bit, result_sr[WIDTH-1:1]} (full result).
    - Cout<=c1|c2, Done<=1, Busy<=0, go to DONE.
- DONE:
  - Done held for exactly this cycle.
  - Next edge: Done<=0, go to IDLE.
  - Start is ignored in this state.
- Latency:
  - Start sampled at edge k → Busy high over edges k..k+WIDTH.
  - Sum/Cout update and Done rises at edge k+WIDTH.
  - Done falls at k+WIDTH+1.
  - Next Start is accepted at edge k+WIDTH+2 at the earliest.
- Output stability:
  - Sum/Cout change only at the completion edge.
  - They hold their value through subsequent IDLE cycles until the next completion.
  - They never show partial results.
- Arithmetic: {Cout,Sum} == A+B+Cin (mod 2^(WIDTH+1)), computed on the values captured at accept.
- Boundary conditions:
  - Start while Busy or Done: ignored, with no effect on the in-flight operation.
  - A/B/Cin changing after accept: no effect.
  - Start held high continuously: one operation per WIDTH+2 cycles.
  - Reset asserted mid-RUN: immediately (asynchronously) forces all reset values, and the in-flight result is discarded.
  - After Reset deasserts, the first Start behaves normally.
  - Counter must not wrap: it is sized ceil(log2(WIDTH))+1 bits.

Test Plan:
- Reset check: assert Reset without a clock edge → Busy=0, Done=0, Sum=8'h00, Cout=0. Then hold Start=0 for 10 cycles → outputs unchanged.
- Basic add: A=8'h5A, B=8'h3C, Cin=0, Start at edge k → Busy=1 for 8 cycles, Done=1 only in the cycle after edge k+8, Sum=8'h96, Cout=0.
- Full carry propagation: A=8'hFF, B=8'h01, Cin=0 → Sum=8'h00, Cout=1. Then A=8'hFF, B=8'hFF, Cin=1 → Sum=8'hFF, Cout=1.
- Handshake: pulse Start again at edges k+3 and k+8 with A=8'h01, B=8'h01 → ignored. Result stays that of the first operation, and exactly one Done pulse occurs.
- Reset mid-run: Start A=8'h77, B=8'h11, then assert Reset at k+3 → immediately Busy=0, Sum=0, and no Done. Release Reset, Start A=8'h10, B=8'h20, Cin=1 → Sum=8'h31, Cout=0.
- Random regression: 200 back-to-back ops with random A/B/Cin (also WIDTH=4 build) → every Done shows {Cout,Sum}==A+B+Cin, and Done spacing is WIDTH+2 cycles with Start held high.
